// File: rtl/sort_pkg.sv
// Shared widths, the sorted-word type and the thermometer-code ones counter
// used by the sort arbiter.
package sort_pkg;
    localparam int SORT_W = 16;
    localparam int CNT_W  = 5;

    typedef logic [SORT_W-1:0] sort_word_t;

    // Leading ones from bit 15: the highest zero bit fixes the count.
    function automatic logic [CNT_W-1:0] thermo_count(input sort_word_t w);
        logic [CNT_W-1:0] c;
        c = CNT_W'(SORT_W);
        for (int i = 0; i < SORT_W; i++) begin
            if (!w[i]) c = CNT_W'(SORT_W - 1 - i);
        end
        return c;
    endfunction
endpackage

// File: rtl/bitonic_sort_16.sv
// 16-input bitonic network on single bits. Compare-exchange reduces to
// AND (min) / OR (max), and the ones end up packed toward bit 15.
import sort_pkg::*;

module bitonic_sort_16 (
    input  sort_word_t data_i,
    output sort_word_t sorted_o
);
    sort_word_t v;
    int         l;
    logic       a, b;

    always_comb begin
        v = data_i;
        l = 0;
        a = 1'b0;
        b = 1'b0;
        for (int ks = 1; ks <= 4; ks++) begin
            for (int js = ks - 1; js >= 0; js--) begin
                for (int i = 0; i < SORT_W; i++) begin
                    l = i ^ (1 << js);
                    if (l > i) begin
                        a = v[i];
                        b = v[l];
                        // Ascending blocks put the max at the higher index.
                        if ((i & (1 << ks)) == 0) begin
                            v[i] = a & b;
                            v[l] = a | b;
                        end else begin
                            v[i] = a | b;
                            v[l] = a & b;
                        end
                    end
                end
            end
        end
        sorted_o = v;
    end
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The search starts at ptr and wraps
// modulo NREQ. The grant is one-hot, or zero when nothing is requesting.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_idx
);
    logic found;
    int   idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int off = 0; off < NREQ; off++) begin
            idx = int'(ptr) + off;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = ID_W'(idx);
            end
        end
    end
endmodule

// File: rtl/sort_arbiter.sv
// Shares one bitonic bit-sorter among NREQ requesters through a round-robin
// arbiter and a two-stage valid/ready pipeline (capture, then output).
import sort_pkg::*;

module sort_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [SORT_W*NREQ-1:0] req_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ID_W-1:0]        out_id,
    output logic [SORT_W-1:0]      out_sorted,
    output logic [CNT_W-1:0]       out_count,
    output logic                   busy
);
    logic [NREQ-1:0] grant;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    sort_word_t      grant_data;
    sort_word_t      sorted;
    logic            s1_load_ok, s2_load_ok, accept;

    logic            s1_valid_q;
    sort_word_t      s1_data_q;
    logic [ID_W-1:0] s1_id_q;

    logic            out_valid_q;
    logic [ID_W-1:0] out_id_q;
    sort_word_t      out_sorted_q;
    logic [CNT_W-1:0] out_count_q;

    rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign s2_load_ok = !out_valid_q | out_ready;
    assign s1_load_ok = !s1_valid_q | s2_load_ok;
    assign req_ready  = grant & {NREQ{s1_load_ok & !rst}};
    assign accept     = |req_ready;

    // AND-OR mux; the grant is one-hot so at most one lane contributes.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant_data = grant_data | (req_data[SORT_W*i +: SORT_W] & {SORT_W{grant[i]}});
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + ID_W'(1);
        end
    end

    bitonic_sort_16 u_sort (
        .data_i   (s1_data_q),
        .sorted_o (sorted)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            s1_id_q      <= '0;
            out_valid_q  <= 1'b0;
            out_id_q     <= '0;
            out_sorted_q <= '0;
            out_count_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (s1_load_ok) begin
                s1_valid_q <= accept;
                if (accept) begin
                    s1_data_q <= grant_data;
                    s1_id_q   <= grant_idx;
                end
            end
            if (s2_load_ok) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_id_q     <= s1_id_q;
                    out_sorted_q <= sorted;
                    out_count_q  <= thermo_count(sorted);
                end
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_id     = out_id_q;
    assign out_sorted = out_sorted_q;
    assign out_count  = out_count_q;
    assign busy       = s1_valid_q | out_valid_q;
endmodule

// File: tb/tb_sort_arbiter.sv
// Directed bench for sort_arbiter: a sort/count vector table plus hand-written
// round-robin, backpressure, reset and NREQ=3 fairness sequences.
module tb_sort_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_ready;
    logic [63:0] req_data;
    logic        out_valid, out_ready, busy;
    logic [1:0]  out_id;
    logic [15:0] out_sorted;
    logic [4:0]  out_count;

    logic [2:0]  r3_valid, r3_ready;
    logic [47:0] r3_data;
    logic        r3_out_valid, r3_busy;
    logic [1:0]  r3_out_id;
    logic [15:0] r3_out_sorted;
    logic [4:0]  r3_out_count;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sort_arbiter #(.NREQ(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_id(out_id), .out_sorted(out_sorted), .out_count(out_count), .busy(busy)
    );

    sort_arbiter #(.NREQ(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(r3_valid), .req_ready(r3_ready),
        .req_data(r3_data), .out_valid(r3_out_valid), .out_ready(1'b1),
        .out_id(r3_out_id), .out_sorted(r3_out_sorted), .out_count(r3_out_count), .busy(r3_busy)
    );

    typedef struct {
        int          id;
        logic [15:0] data;
        logic [15:0] sorted;
        logic [4:0]  cnt;
    } vec_t;

    vec_t vt[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int exp_id, acc, last, g2;
        logic [3:0] pend;
        int q_id[$];
        int q_cnt[$];

        vt[0] = '{0, 16'h00F0, 16'hF000, 5'd4};
        vt[1] = '{1, 16'h0000, 16'h0000, 5'd0};
        vt[2] = '{2, 16'hFFFF, 16'hFFFF, 5'd16};
        vt[3] = '{3, 16'h8001, 16'hC000, 5'd2};
        vt[4] = '{1, 16'h1234, 16'hF800, 5'd5};
        vt[5] = '{2, 16'hA5A5, 16'hFF00, 5'd8};
        vt[6] = '{3, 16'h0001, 16'h8000, 5'd1};

        rst = 1'b1;
        req_valid = 4'hF;
        req_data = '0;
        out_ready = 1'b1;
        r3_valid = '0;
        r3_data = '0;
        #1;
        check("ready_in_reset", 32'(req_ready), 32'h0);
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_id", 32'(out_id), 32'h0);
        check("rst_out_sorted", 32'(out_sorted), 32'h0);
        check("rst_out_count", 32'(out_count), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_rr_ptr", 32'(dut.rr_ptr_q), 32'h0);
        check("rst_s1_valid", 32'(dut.s1_valid_q), 32'h0);
        req_valid = '0;
        rst = 1'b0;
        step();

        // Single-request sort vectors; latency is two edges from accept.
        for (int v = 0; v < 7; v++) begin
            req_data = '0;
            req_data[16*vt[v].id +: 16] = vt[v].data;
            req_valid = 4'(1) << vt[v].id;
            #1;
            check("vec_ready", 32'(req_ready), 32'(4'(1) << vt[v].id));
            step();
            req_valid = '0;
            check("vec_not_yet", 32'(out_valid), 32'h0);
            step();
            check("vec_valid", 32'(out_valid), 32'h1);
            check("vec_sorted", 32'(out_sorted), 32'(vt[v].sorted));
            check("vec_count", 32'(out_count), 32'(vt[v].cnt));
            check("vec_id", 32'(out_id), 32'(vt[v].id));
            step();
        end

        // Round robin at full throughput.
        do_reset();
        req_data = {16'h000F, 16'h0007, 16'h0003, 16'h0001};
        req_valid = 4'hF;
        exp_id = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            check("rr_onehot", 32'($countones(req_ready)), 32'h1);
            step();
            if (c >= 1) begin
                check("rr_valid", 32'(out_valid), 32'h1);
                check("rr_id", 32'(out_id), 32'(exp_id));
                check("rr_count", 32'(out_count), 32'(exp_id + 1));
                exp_id = (exp_id + 1) % 4;
            end
        end
        req_valid = '0;
        repeat (3) step();

        // Backpressure: five stalled cycles, then drain in order.
        do_reset();
        pend = 4'hF;
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            req_valid = pend;
            #1;
            if (c >= 2) check("bp_ready_zero", 32'(req_ready), 32'h0);
            if (|req_ready) acc++;
            pend = pend & ~req_ready;
            step();
            if (c >= 2) begin
                check("bp_hold_valid", 32'(out_valid), 32'h1);
                check("bp_hold_id", 32'(out_id), 32'h0);
                check("bp_hold_sorted", 32'(out_sorted), 32'h8000);
                check("bp_hold_count", 32'(out_count), 32'h1);
            end
        end
        check("bp_accepts", 32'(acc), 32'h2);
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            req_valid = pend;
            #1;
            if (out_valid) begin
                q_id.push_back(int'(out_id));
                q_cnt.push_back(int'(out_count));
            end
            pend = pend & ~req_ready;
            step();
        end
        req_valid = '0;
        check("bp_drain_n", 32'(q_id.size()), 32'h4);
        for (int i = 0; i < q_id.size() && i < 4; i++) begin
            check("bp_drain_id", 32'(q_id[i]), 32'(i));
            check("bp_drain_cnt", 32'(q_cnt[i]), 32'(i + 1));
        end

        // Reset one cycle after an accept.
        do_reset();
        req_valid = 4'b0010;
        step();
        rst = 1'b1;
        req_valid = 4'hF;
        #1;
        check("mid_ready_in_rst", 32'(req_ready), 32'h0);
        step();
        check("mid_out_valid", 32'(out_valid), 32'h0);
        check("mid_busy", 32'(busy), 32'h0);
        check("mid_rr_ptr", 32'(dut.rr_ptr_q), 32'h0);
        rst = 1'b0;
        req_valid = 4'b1100;
        #1;
        check("mid_first_grant", 32'(req_ready), 32'b0100);
        step();
        req_valid = '0;
        check("mid_no_partial", 32'(out_valid), 32'h0);
        step();
        check("mid_out_valid2", 32'(out_valid), 32'h1);
        check("mid_out_id", 32'(out_id), 32'h2);
        step();
        check("mid_drained", 32'(busy), 32'h0);

        // NREQ=3 fairness: req2 held, req0 toggling.
        do_reset();
        last = -1;
        g2 = 0;
        for (int c = 0; c < 24; c++) begin
            r3_valid = {1'b1, 1'b0, c[0] == 1'b0};
            #1;
            check("f3_onehot", 32'($countones(r3_ready)), 32'h1);
            if (r3_ready[2]) begin
                if (last >= 0) check("f3_gap_le3", 32'((c - last) <= 3), 32'h1);
                last = c;
                g2++;
                step();
                check("f3_wrap", 32'(dut3.rr_ptr_q), 32'h0);
            end else begin
                step();
            end
        end
        r3_valid = '0;
        check("f3_grants", 32'(g2 >= 8), 32'h1);
        check("f3_recent", 32'(last >= 20), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
